mem_stage_lsu: RTL
==================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 255, meaning the maximum number of cycles spent in WAIT before an abort (range 1..255).
REQ-002 SHALL have one clock, `clk`, input, 1 bit; all state is updated on its rising edge.
REQ-003 SHALL have `rst`, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have these exec-side inputs:
- ex_valid, 1: instruction presented.
- ex_is_load / ex_is_store, 1 each.
- ex_funct3, 3: LB/LH/LW/LBU/LHU/SB/SH/SW encoding.
- ex_addr, 32: effective address.
- ex_store_data, 32.
- ex_alu_result, 32.
- ex_rd, 5.
- ex_write_reg, 1.
- ex_pc, 32.
REQ-005 SHALL output ex_ready, 1 bit: the stage register accepts this cycle.
REQ-006 SHALL have these stage outputs:
- mem_valid, 1.
- destination_reg_stage2, 5.
- write_reg_stage2, 1.
- rd_result_stage2, 32.
- PC_stage2, 32.
- memstage_load_into_reg, 1.
- load_data_valid, 1.
- misalign_exc, 1.
- bus_err, 1.
REQ-007 SHALL have these data-memory ports:
- dmem_req out 1.
- dmem_we out 1.
- dmem_addr out 32, word-aligned.
- dmem_wdata out 32.
- dmem_wstrb out 4.
- dmem_gnt in 1.
- dmem_rvalid in 1.
- dmem_rdata in 32.

Function
REQ-008 SHALL implement states IDLE, REQ, WAIT, DONE. ex_ready is 1 in IDLE and DONE, and 0 in REQ and WAIT.
REQ-009 SHALL capture all ex_* fields into the stage register on ex_valid && ex_ready.
- Non-memory instruction: go to IDLE; mem_valid=1 next cycle; rd_result_stage2=ex_alu_result.
- Load or store: go to REQ; mem_valid=0 until DONE.
REQ-010 In REQ, SHALL assert dmem_req with stable addr/we/wdata/wstrb until dmem_gnt is sampled high.
- Store + gnt: go to DONE.
- Load + gnt: go to WAIT.
REQ-011 A gnt and rvalid arriving in the same cycle while in REQ SHALL complete the load directly to DONE.
REQ-012 In WAIT, dmem_rvalid SHALL latch the extracted data into rd_result_stage2 and go to DONE.
REQ-013 In DONE, SHALL drive mem_valid=1 for exactly one cycle. A new capture that cycle re-enters REQ or IDLE per REQ-009; with no capture, go to IDLE with mem_valid=0.
REQ-014 memstage_load_into_reg SHALL be 1 whenever the held instruction is a load (states REQ, WAIT, DONE).
REQ-015 load_data_valid SHALL be 1 only in DONE for a load; it is 0 in REQ and WAIT, so forwarding logic stalls.
REQ-016 Load extraction SHALL select the byte or halfword by ex_addr[1:0].
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: pass through.
REQ-017 Store formatting SHALL replicate the byte or halfword across dmem_wdata.
- SB: wstrb=1<<addr[1:0].
- SH: wstrb=4'b0011<<addr[1:0].
- SW: wstrb=4'b1111.
REQ-018 dmem_addr SHALL equal {addr[31:2],2'b00}.
REQ-019 The WAIT cycle counter SHALL saturate at RESP_TIMEOUT.
- On reaching RESP_TIMEOUT: go to DONE, bus_err=1 for that DONE cycle, write_reg_stage2=0.
- An rvalid arriving later SHALL be ignored.
REQ-020 dmem_rvalid outside WAIT (and outside REQ+gnt) SHALL be ignored.

Reset
REQ-021 On rst, SHALL go to IDLE and set all outputs to 0 in the following cycle: mem_valid, dmem_req, dmem_we, dmem_wstrb, write_reg_stage2, memstage_load_into_reg, load_data_valid, misalign_exc, bus_err, and all data/address registers.
REQ-022 rst asserted in REQ or WAIT SHALL abandon the access without a register write; an rvalid in the cycle after reset SHALL be ignored.

Configuration
REQ-023 Macro LSU_MISALIGN_TRAP_EN defined:
- A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL skip REQ and go straight to DONE.
- In that DONE cycle: misalign_exc=1, write_reg_stage2=0, no dmem_req.
REQ-024 Macro LSU_MISALIGN_TRAP_EN undefined: misalign_exc SHALL be tied to 0, and misaligned accesses SHALL proceed with the strobe/shift of REQ-016/017, with bits beyond the word truncated.

Verification
REQ-025 SHALL cover:
- LW at 0x100, gnt at cycle+1, rvalid at cycle+3 with 0xDEADBEEF -> load_data_valid=1, rd_result_stage2=0xDEADBEEF, mem_valid pulse of 1 cycle.
- LB at 0x103, rdata=0x80FF_FF7F -> rd_result_stage2=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x202, data 0x1234ABCD -> dmem_addr=0x200, wstrb=4'b1100, wdata=0xABCDABCD, DONE after gnt with no rvalid needed.
- Load with rvalid never returned and RESP_TIMEOUT=4 -> bus_err=1 after 4 WAIT cycles, write_reg_stage2=0.
- rst asserted in WAIT, followed by a stale rvalid -> state IDLE, all outputs 0, no mem_valid.
- With LSU_MISALIGN_TRAP_EN, LW at 0x101 -> misalign_exc=1, dmem_req never asserted.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// Memory stage / load-store unit for a simple in-order pipeline. Holds one
// instruction in a stage register, performs at most one data-memory access
// for it (req/gnt handshake, then rvalid for loads) and presents the result
// to the write-back side for exactly one cycle.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses skip the bus and report
//               misalign_exc in their DONE cycle without a register write.
//   undefined : misalign_exc is tied low; misaligned accesses go to the bus
//               with the usual byte shift/strobe and out-of-word bits dropped.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   ex_*                   : instruction presented by the execute stage
//   ex_ready               : stage register accepts this cycle
//   mem_valid ... bus_err  : stage-2 outputs toward write-back / forwarding
//   dmem_*                 : data-memory request/response channel
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
   parameter int unsigned RESP_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_is_load,
   input  logic        ex_is_store,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_store_data,
   input  logic [31:0] ex_alu_result,
   input  logic [4:0]  ex_rd,
   input  logic        ex_write_reg,
   input  logic [31:0] ex_pc,
   output logic        ex_ready,
   output logic        mem_valid,
   output logic [4:0]  destination_reg_stage2,
   output logic        write_reg_stage2,
   output logic [31:0] rd_result_stage2,
   output logic [31:0] PC_stage2,
   output logic        memstage_load_into_reg,
   output logic        load_data_valid,
   output logic        misalign_exc,
   output logic        bus_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Last counter value before the WAIT timeout fires.
   localparam logic [7:0] TMO_LAST = 8'(RESP_TIMEOUT - 1);

   // Select the addressed byte/halfword of a read word and extend it.
   function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [31:0] rdata);
      logic [31:0] sh;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
         3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
         3'b100:  load_extract = {24'd0, sh[7:0]};
         3'b101:  load_extract = {16'd0, sh[15:0]};
         default: load_extract = sh;
      endcase
   endfunction

   // Replicate store data so every byte lane carries the right value.
   function automatic logic [31:0] store_wdata(input logic [2:0] f3,
                                               input logic [31:0] data);
      case (f3[1:0])
         2'b00:   store_wdata = {4{data[7:0]}};
         2'b01:   store_wdata = {2{data[15:0]}};
         default: store_wdata = data;
      endcase
   endfunction

   // Byte-enable pattern; shifted-out lanes of a misaligned access are dropped.
   function automatic logic [3:0] store_wstrb(input logic [2:0] f3,
                                              input logic [1:0] off);
      case (f3[1:0])
         2'b00:   store_wstrb = 4'b0001 << off;
         2'b01:   store_wstrb = 4'b0011 << off;
         default: store_wstrb = 4'b1111;
      endcase
   endfunction

   state_e      state_q, state_d;
   logic        is_load_q, is_load_d;
   logic        is_store_q, is_store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [4:0]  rd_q, rd_d;
   logic        write_reg_q, write_reg_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] result_q, result_d;
   logic        mem_valid_q, mem_valid_d;
   logic        bus_err_q, bus_err_d;
   logic        misalign_q, misalign_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        capture_s;
   logic        misaligned_s;
   logic [31:0] ld_data_s;

   assign capture_s = ex_valid && ex_ready;
   assign ld_data_s = load_extract(funct3_q, addr_q[1:0], dmem_rdata);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned_s = (ex_is_load || ex_is_store) &&
                         (((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                          ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00)));
`else
   assign misaligned_s = 1'b0;
`endif

   // Next-state and stage-register update logic.
   always_comb begin
      state_d     = state_q;
      is_load_d   = is_load_q;
      is_store_d  = is_store_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rd_d        = rd_q;
      write_reg_d = write_reg_q;
      pc_d        = pc_q;
      result_d    = result_q;
      cnt_d       = cnt_q;
      mem_valid_d = 1'b0;
      bus_err_d   = 1'b0;
      misalign_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (capture_s) begin
               is_load_d   = ex_is_load;
               is_store_d  = ex_is_store && !ex_is_load;
               funct3_d    = ex_funct3;
               addr_d      = ex_addr;
               wdata_d     = store_wdata(ex_funct3, ex_store_data);
               wstrb_d     = store_wstrb(ex_funct3, ex_addr[1:0]);
               rd_d        = ex_rd;
               write_reg_d = ex_write_reg;
               pc_d        = ex_pc;
               result_d    = ex_alu_result;
               if (misaligned_s) begin
                  state_d     = S_DONE;
                  mem_valid_d = 1'b1;
                  misalign_d  = 1'b1;
                  write_reg_d = 1'b0;
               end else if (ex_is_load || ex_is_store) begin
                  state_d = S_REQ;
               end else begin
                  state_d     = S_IDLE;
                  mem_valid_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (dmem_gnt) begin
               if (is_store_q) begin
                  state_d     = S_DONE;
                  mem_valid_d = 1'b1;
               end else if (dmem_rvalid) begin
                  // Zero-latency response completes the load right away.
                  state_d     = S_DONE;
                  mem_valid_d = 1'b1;
                  result_d    = ld_data_s;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 8'd0;
               end
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (dmem_rvalid) begin
               state_d     = S_DONE;
               mem_valid_d = 1'b1;
               result_d    = ld_data_s;
            end else if (cnt_q >= TMO_LAST) begin
               // Response never came: abort without a register write.
               state_d     = S_DONE;
               mem_valid_d = 1'b1;
               bus_err_d   = 1'b1;
               write_reg_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Stage register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         is_load_q   <= 1'b0;
         is_store_q  <= 1'b0;
         funct3_q    <= 3'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         wstrb_q     <= 4'd0;
         rd_q        <= 5'd0;
         write_reg_q <= 1'b0;
         pc_q        <= 32'd0;
         result_q    <= 32'd0;
         mem_valid_q <= 1'b0;
         bus_err_q   <= 1'b0;
         misalign_q  <= 1'b0;
         cnt_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         is_load_q   <= is_load_d;
         is_store_q  <= is_store_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rd_q        <= rd_d;
         write_reg_q <= write_reg_d;
         pc_q        <= pc_d;
         result_q    <= result_d;
         mem_valid_q <= mem_valid_d;
         bus_err_q   <= bus_err_d;
         misalign_q  <= misalign_d;
         cnt_q       <= cnt_d;
      end
   end

   // All outputs decode directly from flops.
   assign ex_ready               = (state_q == S_IDLE) || (state_q == S_DONE);
   assign mem_valid              = mem_valid_q;
   assign destination_reg_stage2 = rd_q;
   assign write_reg_stage2       = write_reg_q;
   assign rd_result_stage2       = result_q;
   assign PC_stage2              = pc_q;
   assign memstage_load_into_reg = is_load_q && (state_q != S_IDLE);
   assign load_data_valid        = is_load_q && (state_q == S_DONE) && !bus_err_q && !misalign_q;
   assign misalign_exc           = misalign_q;
   assign bus_err                = bus_err_q;
   assign dmem_req               = (state_q == S_REQ);
   assign dmem_we                = (state_q == S_REQ) && is_store_q;
   assign dmem_addr              = {addr_q[31:2], 2'b00};
   assign dmem_wdata             = wdata_q;
   assign dmem_wstrb             = ((state_q == S_REQ) && is_store_q) ? wstrb_q : 4'b0000;

endmodule
